// File: rtl/hbb_arb_pkg.sv
// Shared arbitration types and a behavioural reference picker for the one-hot mux arbiter.
// Holds the state encoding, default requester count and the rr_pick helper.
package hbb_arb_pkg;

    localparam int unsigned ARB_N_DEFAULT  = 8;
    localparam int unsigned ARB_IW_DEFAULT = $clog2(ARB_N_DEFAULT);

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    typedef struct packed {
        logic                      found;
        logic [ARB_IW_DEFAULT-1:0] idx;
    } arb_pick_t;

    // Linear rotating scan from ptr; bits set in exclude never win.
    function automatic arb_pick_t rr_pick(
        input logic [ARB_N_DEFAULT-1:0]  req,
        input logic [ARB_IW_DEFAULT-1:0] ptr,
        input logic [ARB_N_DEFAULT-1:0]  exclude
    );
        arb_pick_t   res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < ARB_N_DEFAULT; k++) begin
            j = (int'(ptr) + k) % ARB_N_DEFAULT;
            if (!res.found && req[j] && !exclude[j]) begin
                res.found = 1'b1;
                res.idx   = ARB_IW_DEFAULT'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational rotating-priority finder: masks excluded requests, rotates by ptr
// through a doubled vector, then priority-encodes the lowest set bit.
module rr_pick_comb #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  excl,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0]   masked;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rot;
    logic [IW:0]    pos;
    logic [IW:0]    sum;

    always_comb begin
        masked  = req & ~excl;
        dbl     = {masked, masked};
        shifted = dbl >> ptr;
        rot     = shifted[N-1:0];
        found   = |rot;

        // Descending scan leaves pos at the lowest set bit of the rotated vector.
        pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = (IW + 1)'(i);
            end
        end

        sum = pos + {1'b0, ptr};
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/rr_arbiter_1hot.sv
// Round-robin arbiter driving a one-hot mux select; grants are held until done.
// Optional ARB_LOCK_EN adds a lock input that keeps the grant across done.
module rr_arbiter_1hot
    import hbb_arb_pkg::*;
#(
    parameter int unsigned N  = ARB_N_DEFAULT,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          done,
`ifdef ARB_LOCK_EN
    input  logic          lock,
`endif
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    arb_state_t    state_q;
    logic [IW-1:0] ptr_q;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] idx_q;
    logic          valid_q;

    logic          lock_hold;
    logic          rearb;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] pick_ptr;
    logic [N-1:0]  pick_excl;
    logic          pick_found;
    logic [IW-1:0] pick_idx;

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        rearb     = (state_q == ARB_BUSY) && done && !lock_hold;
        next_ptr  = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
        // On re-arbitration the scan starts past the grantee and skips it.
        pick_ptr  = rearb ? next_ptr : ptr_q;
        pick_excl = rearb ? grant_q : '0;
    end

    rr_pick_comb #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .excl  (pick_excl),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_q <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                        idx_q   <= pick_idx;
                        valid_q <= 1'b1;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (rearb) begin
                        ptr_q <= next_ptr;
                        if (pick_found) begin
                            grant_q <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                            idx_q   <= pick_idx;
                        end else begin
                            grant_q <= '0;
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            state_q <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));

    a_valid_matches : assert property (@(posedge clk) disable iff (!rst_n)
        valid_q == (|grant_q));

    a_idle_zero : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ARB_IDLE) |-> (grant_q == '0 && idx_q == '0));

endmodule

// File: tb/tb_rr_arbiter_1hot.sv
// Scoreboard bench for rr_arbiter_1hot; a behavioural model predicts each cycle's grant.
module tb_rr_arbiter_1hot;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       lock_s;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_idx;

`ifdef ARB_LOCK_EN
    localparam bit LockSupported = 1'b1;
`else
    localparam bit LockSupported = 1'b0;
`endif

    rr_arbiter_1hot #(
        .N  (8),
        .IW (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
`ifdef ARB_LOCK_EN
        .lock        (lock_s),
`endif
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream one-hot mux with default, modelled in the bench.
    logic [7:0] mux_data [8];
    logic [7:0] dflt;
    logic [7:0] mux_out;
    always_comb begin
        mux_out = '0;
        for (int i = 0; i < 8; i++) begin
            mux_out = mux_out | ({8{grant[i]}} & mux_data[i]);
        end
        if (grant == 8'h00) mux_out = dflt;
    end

    typedef struct {
        logic [7:0] g;
        logic       v;
        logic [2:0] i;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   fails   = 0;

    // Reference model state
    bit   m_busy;
    int   m_ptr;
    int   m_idx;

    function automatic int scan(input logic [7:0] r, input int p, input int ex);
        int j;
        for (int k = 0; k < 8; k++) begin
            j = (p + k) % 8;
            if (r[j] && j != ex) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr  = 0;
        m_idx  = 0;
        sbq.delete();
    endtask

    task automatic model_advance(input logic [7:0] r, input logic d, input logic l);
        int  w;
        int  p;
        bit  hold;
        hold = l && LockSupported;
        if (!m_busy) begin
            w = scan(r, m_ptr, -1);
            if (w >= 0) begin
                m_busy = 1'b1;
                m_idx  = w;
            end
        end else if (d && !hold) begin
            p     = (m_idx + 1) % 8;
            m_ptr = p;
            w     = scan(r, p, m_idx);
            if (w >= 0) m_idx = w;
            else begin
                m_busy = 1'b0;
                m_idx  = 0;
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input logic d, input logic l);
        exp_t e;
        @(negedge clk);
        req    = r;
        done   = d;
        lock_s = l;
        model_advance(r, d, l);
        e.g = m_busy ? (8'h01 << m_idx) : 8'h00;
        e.v = m_busy;
        e.i = m_busy ? 3'(m_idx) : 3'd0;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        vectors++;
        if (sbq.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e = sbq.pop_front();
            if ({grant, grant_valid, grant_idx} !== {e.g, e.v, e.i}) begin
                fails++;
                $display("FAIL sb_grant: got grant=%h valid=%b idx=%0d, want grant=%h valid=%b idx=%0d",
                         grant, grant_valid, grant_idx, e.g, e.v, e.i);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        req    = '0;
        done   = 1'b0;
        lock_s = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({grant, grant_valid, grant_idx} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got grant=%h valid=%b idx=%0d, want all zero",
                     grant, grant_valid, grant_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        step(8'h04, 1'b0, 1'b0);
        vectors++;
        if (grant !== 8'h04) begin
            fails++;
            $display("FAIL reset_pre_grant: got %h want 04", grant);
        end
        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (grant !== 8'h00 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got grant=%h valid=%b want 00/0", grant, grant_valid);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h04, 1'b0, 1'b0);
        vectors++;
        if (grant !== 8'h04 || grant_idx !== 3'd2) begin
            fails++;
            $display("FAIL reset_regrant: got grant=%h idx=%0d want 04/2", grant, grant_idx);
        end
    endtask

    task automatic test_idle_default();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(8'h00, k[0], 1'b0);
            vectors++;
            if (grant !== 8'h00 || mux_out !== dflt) begin
                fails++;
                $display("FAIL idle_default: got grant=%h mux=%h want 00/%h", grant, mux_out, dflt);
            end
        end
    endtask

    task automatic test_rotation();
        logic [7:0] want;
        do_reset();
        step(8'hFF, 1'b0, 1'b0);
        vectors++;
        if (grant !== 8'h01) begin
            fails++;
            $display("FAIL rotation_first: got %h want 01", grant);
        end
        for (int k = 1; k <= 8; k++) begin
            step(8'hFF, 1'b1, 1'b0);
            want = 8'h01 << (k % 8);
            vectors++;
            if (grant !== want || mux_out !== mux_data[k % 8]) begin
                fails++;
                $display("FAIL rotation_seq: got grant=%h mux=%h want %h/%h",
                         grant, mux_out, want, mux_data[k % 8]);
            end
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        step(8'h20, 1'b0, 1'b0);
        step(8'h40, 1'b1, 1'b0);
        vectors++;
        if (grant !== 8'h40 || grant_idx !== 3'd6) begin
            fails++;
            $display("FAIL wrap_setup: got grant=%h idx=%0d want 40/6", grant, grant_idx);
        end
        step(8'h21, 1'b1, 1'b0);
        vectors++;
        if (grant !== 8'h01 || grant_idx !== 3'd0) begin
            fails++;
            $display("FAIL wrap_skip: got grant=%h idx=%0d want 01/0", grant, grant_idx);
        end
    endtask

    task automatic test_hold();
        do_reset();
        step(8'h02, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(8'h00, 1'b0, 1'b0);
            vectors++;
            if (grant !== 8'h02) begin
                fails++;
                $display("FAIL hold_grant: got %h want 02", grant);
            end
        end
        step(8'h00, 1'b1, 1'b0);
        vectors++;
        if (grant !== 8'h00 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: got grant=%h valid=%b want 00/0", grant, grant_valid);
        end
        // done while idle must not move ptr (left at 2 by the release)
        step(8'h00, 1'b1, 1'b0);
        step(8'hFF, 1'b0, 1'b0);
        vectors++;
        if (grant !== 8'h04) begin
            fails++;
            $display("FAIL idle_ptr_static: got %h want 04", grant);
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        step(8'h03, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(8'h03, 1'b1, 1'b1);
            vectors++;
            if (grant !== 8'h01) begin
                fails++;
                $display("FAIL lock_hold: got %h want 01", grant);
            end
        end
        step(8'h03, 1'b1, 1'b0);
        vectors++;
        if (grant !== 8'h02) begin
            fails++;
            $display("FAIL lock_release: got %h want 02", grant);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            step(8'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        done   = 1'b0;
        lock_s = 1'b0;
        dflt   = 8'h5A;
        for (int i = 0; i < 8; i++) mux_data[i] = 8'(8'hA0 + i);
        model_reset();
        test_reset();
        test_idle_default();
        test_rotation();
        test_wrap_skip();
        test_hold();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
